// File: rtl/elbeth_pkg.sv
// Shared encodings for the ELBETH pipeline control slice.
package elbeth_pkg;

    // PC source select
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_XCPT   = 2'd2;
    localparam logic [1:0] PC_EPC    = 2'd3;

    // Pipeline control FSM encoding
    localparam logic [1:0] ST_RUN         = 2'd0;
    localparam logic [1:0] ST_DMEM_WAIT   = 2'd1;
    localparam logic [1:0] ST_XCPT_SETTLE = 2'd2;

    // Byte-enable pattern that marks a load
    localparam logic [3:0] MEM_RW_LOAD = 4'b0000;

    // Hazards seen in the current cycle
    typedef struct packed {
        logic dw;
        logic xcpt;
        logic br;
        logic lu;
    } hazard_t;

    // Load in EXS writes a register that the ID instruction reads
    function automatic logic is_load_use(
        input logic       mem_en,
        input logic [3:0] mem_rw,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       rs1_used,
        input logic [4:0] rs2,
        input logic       rs2_used
    );
        return mem_en && (mem_rw == MEM_RW_LOAD) && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/elbeth_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module elbeth_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count up on inc, hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/elbeth_pipeline_ctrl.sv
// Hazard and pipeline-control unit for the ELBETH five-stage core.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// ST_RUN         | normal issue, hazards resolved by priority
// ST_DMEM_WAIT   | data access outstanding; upstream held, bubble to WB
// ST_XCPT_SETTLE | one cycle after exception/eret while CSRs commit
module elbeth_pipeline_ctrl
    import elbeth_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       exs_rd_addr,
    input  logic             exs_ctrl_mem_en,
    input  logic [3:0]       exs_ctrl_mem_rw,
    input  logic             exs_branch_taken,
    input  logic             mem_exception,
    input  logic             mem_eret,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             if_stall,
    output logic             if_flush,
    output logic             id_stall,
    output logic             id_flush,
    output logic             exs_stall,
    output logic             exs_flush,
    output logic             mem_stall,
    output logic             mem_flush,
    output logic [1:0]       pc_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    hazard_t    hz;
    logic       flush_evt;

    // Decode this cycle's hazards
    always_comb begin
        hz.dw   = dmem_req && !dmem_ready;
        hz.xcpt = mem_exception || mem_eret;
        hz.br   = exs_branch_taken;
        hz.lu   = is_load_use(exs_ctrl_mem_en, exs_ctrl_mem_rw, exs_rd_addr,
                              id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used);
    end

    // Stall/flush/pc_sel and next state; DMEM_WAIT re-evaluates the RUN
    // priorities so the ready cycle is handled without an extra bubble
    always_comb begin
        if_stall  = 1'b0;
        if_flush  = 1'b0;
        id_stall  = 1'b0;
        id_flush  = 1'b0;
        exs_stall = 1'b0;
        exs_flush = 1'b0;
        mem_stall = 1'b0;
        mem_flush = 1'b0;
        pc_sel    = PC_PLUS4;
        flush_evt = 1'b0;
        state_nxt = ST_RUN;

        if (!rst) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            exs_flush = 1'b1;
            mem_flush = 1'b1;
        end else if (state == ST_XCPT_SETTLE) begin
            if_stall = 1'b1;
            if_flush = 1'b1;
        end else if (hz.dw) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            exs_stall = 1'b1;
            mem_flush = 1'b1;
            state_nxt = ST_DMEM_WAIT;
        end else if (hz.xcpt) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            exs_flush = 1'b1;
            mem_flush = 1'b1;
            pc_sel    = mem_exception ? PC_XCPT : PC_EPC;
            flush_evt = 1'b1;
            state_nxt = ST_XCPT_SETTLE;
        end else if (hz.br) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            pc_sel    = PC_BRANCH;
            flush_evt = 1'b1;
        end else if (hz.lu) begin
            if_stall = 1'b1;
            id_flush = 1'b1;
        end else if (!imem_ready) begin
            if_stall = 1'b1;
            if_flush = 1'b1;
        end
    end

    // State register; reset aborts any multi-cycle sequence
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    elbeth_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (if_stall),
        .count (stall_cycles)
    );

    elbeth_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (flush_evt),
        .count (flush_events)
    );

endmodule

// File: tb/tb_elbeth_pipeline_ctrl.sv
// Self-checking bench for elbeth_pipeline_ctrl: directed table, corner
// sequences and randomized traffic against a behavioural model.
module tb_elbeth_pipeline_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] rd;
        logic       mem_en;
        logic [3:0] mem_rw;
        logic       br;
        logic       exc;
        logic       eret;
        logic       imem_ready;
        logic       dmem_req;
        logic       dmem_ready;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    // {if_stall,if_flush,id_stall,id_flush,exs_stall,exs_flush,mem_stall,mem_flush,pc_sel}
    localparam logic [9:0] O_IDLE  = 10'b00_00_00_00_00;
    localparam logic [9:0] O_RST   = 10'b01_01_01_01_00;
    localparam logic [9:0] O_DW    = 10'b10_10_10_01_00;
    localparam logic [9:0] O_XCPT  = 10'b01_01_01_01_10;
    localparam logic [9:0] O_ERET  = 10'b01_01_01_01_11;
    localparam logic [9:0] O_BR    = 10'b01_01_00_00_01;
    localparam logic [9:0] O_LU    = 10'b10_01_00_00_00;
    localparam logic [9:0] O_IMISS = 10'b11_00_00_00_00;
    localparam logic [9:0] O_SETTL = 10'b11_00_00_00_00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  cur;

    logic [9:0]  o32, o4;
    logic [31:0] st32, fe32;
    logic [3:0]  st4, fe4;

    int  checks = 0;
    int  errors = 0;

    // reference model state
    logic   settle_pending = 1'b0;
    longint n_stall = 0;
    longint n_flush = 0;

    always #5 clk = ~clk;

    elbeth_pipeline_ctrl dut32 (
        .clk(clk), .rst(rst),
        .id_rs1_addr(cur.rs1), .id_rs2_addr(cur.rs2),
        .id_rs1_used(cur.rs1_used), .id_rs2_used(cur.rs2_used),
        .exs_rd_addr(cur.rd), .exs_ctrl_mem_en(cur.mem_en), .exs_ctrl_mem_rw(cur.mem_rw),
        .exs_branch_taken(cur.br), .mem_exception(cur.exc), .mem_eret(cur.eret),
        .imem_ready(cur.imem_ready), .dmem_req(cur.dmem_req), .dmem_ready(cur.dmem_ready),
        .if_stall(o32[9]), .if_flush(o32[8]), .id_stall(o32[7]), .id_flush(o32[6]),
        .exs_stall(o32[5]), .exs_flush(o32[4]), .mem_stall(o32[3]), .mem_flush(o32[2]),
        .pc_sel(o32[1:0]), .stall_cycles(st32), .flush_events(fe32)
    );

    elbeth_pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs1_addr(cur.rs1), .id_rs2_addr(cur.rs2),
        .id_rs1_used(cur.rs1_used), .id_rs2_used(cur.rs2_used),
        .exs_rd_addr(cur.rd), .exs_ctrl_mem_en(cur.mem_en), .exs_ctrl_mem_rw(cur.mem_rw),
        .exs_branch_taken(cur.br), .mem_exception(cur.exc), .mem_eret(cur.eret),
        .imem_ready(cur.imem_ready), .dmem_req(cur.dmem_req), .dmem_ready(cur.dmem_ready),
        .if_stall(o4[9]), .if_flush(o4[8]), .id_stall(o4[7]), .id_flush(o4[6]),
        .exs_stall(o4[5]), .exs_flush(o4[4]), .mem_stall(o4[3]), .mem_flush(o4[2]),
        .pc_sel(o4[1:0]), .stall_cycles(st4), .flush_events(fe4)
    );

    function automatic in_t quiet();
        in_t v;
        v = '0;
        v.imem_ready = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] sat4(input longint n);
        return (n > 15) ? 4'hF : n[3:0];
    endfunction

    // Expected control outputs derived directly from the hazard rules
    function automatic logic [9:0] model_out(input in_t v, input logic rstn, input logic settle);
        logic lu, dw;
        dw = v.dmem_req && !v.dmem_ready;
        lu = v.mem_en && (v.mem_rw == 4'd0) && (v.rd != 5'd0) &&
             ((v.rs1_used && v.rs1 == v.rd) || (v.rs2_used && v.rs2 == v.rd));
        if (!rstn)                return O_RST;
        if (settle)               return O_SETTL;
        if (dw)                   return O_DW;
        if (v.exc)                return O_XCPT;
        if (v.eret)               return O_ERET;
        if (v.br)                 return O_BR;
        if (lu)                   return O_LU;
        if (!v.imem_ready)        return O_IMISS;
        return O_IDLE;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_counts(input string nm);
        check({nm, " counters"}, {64'd0, st32, st4, fe32, fe4},
              {64'd0, n_stall[31:0], sat4(n_stall), n_flush[31:0], sat4(n_flush)});
    endtask

    // One clock: drive at negedge, compare before posedge, advance model at posedge
    task automatic step(input in_t v, input logic rstn, input logic use_exp,
                        input logic [9:0] exp_o, input string nm);
        logic [9:0] m, e;
        logic dw;
        @(negedge clk);
        cur = v;
        rst = rstn;
        #1;
        m = model_out(v, rstn, settle_pending);
        e = use_exp ? exp_o : m;
        check({nm, " outs"}, {108'd0, o32, o4}, {108'd0, e, e});
        check_counts(nm);
        @(posedge clk);
        dw = v.dmem_req && !v.dmem_ready;
        if (!rstn) begin
            n_stall = 0;
            n_flush = 0;
            settle_pending = 1'b0;
        end else begin
            if (m[9]) n_stall++;
            if (!settle_pending && !dw && (v.exc || v.eret || v.br)) n_flush++;
            settle_pending = !settle_pending && !dw && (v.exc || v.eret);
        end
    endtask

    task automatic do_reset();
        step(quiet(), 1'b0, 1'b1, O_RST, "reset");
    endtask

    vec_t tbl[17];

    initial begin
        in_t v, lu_v;
        cur = quiet();

        lu_v = quiet();
        lu_v.mem_en = 1'b1; lu_v.rd = 5'd5; lu_v.rs1 = 5'd5; lu_v.rs1_used = 1'b1;

        for (int i = 0; i < 17; i++) tbl[i].in = quiet();
        tbl[0].exp = O_IDLE;
        tbl[1].in = lu_v;                                              tbl[1].exp = O_LU;
        tbl[2].in = lu_v; tbl[2].in.rd = 5'd0; tbl[2].in.rs1 = 5'd0;   tbl[2].exp = O_IDLE;
        tbl[3].in = lu_v; tbl[3].in.rs1_used = 1'b0; tbl[3].in.rs2 = 5'd5; tbl[3].exp = O_IDLE;
        tbl[4].in = lu_v; tbl[4].in.mem_rw = 4'b0001;                  tbl[4].exp = O_IDLE;
        tbl[5].in = lu_v; tbl[5].in.rs1_used = 1'b0; tbl[5].in.rs2 = 5'd5;
        tbl[5].in.rs2_used = 1'b1;                                     tbl[5].exp = O_LU;
        tbl[6].in.br = 1'b1;                                           tbl[6].exp = O_BR;
        tbl[7].in.exc = 1'b1;                                          tbl[7].exp = O_XCPT;
        tbl[8].in.eret = 1'b1;                                         tbl[8].exp = O_ERET;
        tbl[9].in.exc = 1'b1; tbl[9].in.eret = 1'b1;                   tbl[9].exp = O_XCPT;
        tbl[10].in.imem_ready = 1'b0;                                  tbl[10].exp = O_IMISS;
        tbl[11].in.dmem_req = 1'b1;                                    tbl[11].exp = O_DW;
        tbl[12].in.dmem_req = 1'b1; tbl[12].in.exc = 1'b1; tbl[12].in.br = 1'b1; tbl[12].exp = O_DW;
        tbl[13].in = lu_v; tbl[13].in.br = 1'b1;                       tbl[13].exp = O_BR;
        tbl[14].in = lu_v; tbl[14].in.imem_ready = 1'b0;               tbl[14].exp = O_LU;
        tbl[15].in = lu_v; tbl[15].in.eret = 1'b1; tbl[15].in.br = 1'b1; tbl[15].exp = O_ERET;
        tbl[16].in.dmem_req = 1'b1; tbl[16].in.dmem_ready = 1'b1;      tbl[16].exp = O_IDLE;

        // reset state
        do_reset();
        do_reset();
        #1;
        check("reset counters zero", {64'd0, st32, st4, fe32, fe4}, 128'd0);

        // directed table, each vector followed by a quiet cycle
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].in, 1'b1, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));
            step(quiet(), 1'b1, 1'b0, O_IDLE, $sformatf("vec%0d_after", i));
        end

        // load-use lasts one cycle
        do_reset();
        step(lu_v, 1'b1, 1'b1, O_LU, "lu_bubble");
        step(quiet(), 1'b1, 1'b1, O_IDLE, "lu_release");

        // taken branch bumps flush_events 0 -> 1
        do_reset();
        v = quiet(); v.br = 1'b1;
        step(v, 1'b1, 1'b1, O_BR, "branch");
        #1;
        check("branch flush_events", {96'd0, fe32}, 128'd1);

        // DMEM wait with exception pending behind it
        do_reset();
        v = quiet(); v.dmem_req = 1'b1; v.exc = 1'b1;
        for (int i = 0; i < 3; i++) step(v, 1'b1, 1'b1, O_DW, $sformatf("dwait%0d", i));
        v.dmem_ready = 1'b1;
        step(v, 1'b1, 1'b1, O_XCPT, "dwait_ready_xcpt");
        step(quiet(), 1'b1, 1'b1, O_SETTL, "xcpt_settle");
        step(quiet(), 1'b1, 1'b1, O_IDLE, "after_settle");
        #1;
        check("dwait stall_cycles", {96'd0, st32}, 128'd4);
        check("dwait flush_events", {96'd0, fe32}, 128'd1);

        // reset aborts DMEM_WAIT
        v = quiet(); v.dmem_req = 1'b1;
        step(v, 1'b1, 1'b1, O_DW, "pre_rst_dwait");
        step(v, 1'b0, 1'b1, O_RST, "rst_in_dwait");
        #1;
        check("rst_dwait counters", {64'd0, st32, st4, fe32, fe4}, 128'd0);
        step(quiet(), 1'b1, 1'b1, O_IDLE, "post_rst_dwait");

        // reset aborts XCPT_SETTLE
        v = quiet(); v.exc = 1'b1;
        step(v, 1'b1, 1'b1, O_XCPT, "pre_rst_xcpt");
        step(quiet(), 1'b0, 1'b1, O_RST, "rst_in_settle");
        step(quiet(), 1'b1, 1'b1, O_IDLE, "post_rst_settle");

        // saturation of the narrow counter
        do_reset();
        v = quiet(); v.imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) step(v, 1'b1, 1'b1, O_IMISS, $sformatf("imiss%0d", i));
        #1;
        check("sat stall_cycles w4", {124'd0, st4}, 128'd15);
        check("sat stall_cycles w32", {96'd0, st32}, 128'd20);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = '0;
            v.rs1        = 5'($urandom_range(0, 3));
            v.rs2        = 5'($urandom_range(0, 3));
            v.rd         = 5'($urandom_range(0, 3));
            v.rs1_used   = 1'($urandom_range(0, 1));
            v.rs2_used   = 1'($urandom_range(0, 1));
            v.mem_en     = 1'($urandom_range(0, 1));
            v.mem_rw     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            v.br         = ($urandom_range(0, 5) == 0);
            v.exc        = ($urandom_range(0, 11) == 0);
            v.eret       = ($urandom_range(0, 11) == 0);
            v.imem_ready = ($urandom_range(0, 4) != 0);
            v.dmem_req   = ($urandom_range(0, 3) == 0);
            v.dmem_ready = 1'($urandom_range(0, 1));
            step(v, ($urandom_range(0, 39) != 0), 1'b0, O_IDLE, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
